io_controller: RTL and testbench
================================

IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 SHALL have parameter DBITS, default 32, data word width.
REQ-002 SHALL have parameter ADDR_HEX, default 32'hF0000000, HEX display register address.
REQ-003 SHALL have parameter ADDR_LEDR, default 32'hF0000004, red LED register address.
REQ-004 SHALL have parameter ADDR_LEDG, default 32'hF0000008, green LED address (unpopulated on board).
REQ-005 SHALL have parameter ADDR_KEY, default 32'hF0000010, key state address.
REQ-006 SHALL have parameter ADDR_SW, default 32'hF0000014, switch state address.
REQ-007 SHALL have parameter ADDR_KEYEDGE, default 32'hF0000018, sticky key-press register address.
REQ-008 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable cycles needed to accept a key change; legal range 2 to 2^20.
REQ-009 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-010 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-011 SHALL have port addr  input  DBITS  byte address from ALU result.
REQ-012 SHALL have port wrEn  input  1  store strobe, sampled on rising edge of clk.
REQ-013 SHALL have port dataIn  input  DBITS  store data (rt register value).
REQ-014 SHALL have port dataOut  output  DBITS  load data (ioOut of the datapath).
REQ-015 SHALL have port ioHit  output  1  high when addr matches any decoded address.
REQ-016 SHALL have port KEY  input  4  raw push buttons, active-low, asynchronous.
REQ-017 SHALL have port SW  input  10  raw slide switches, asynchronous.
REQ-018 SHALL have port LEDR  output  10  red LED drive.
REQ-019 SHALL have port hexOut  output  24  six 4-bit digits for the SevenSeg decoders, digit 0 in [3:0].

Function
REQ-020 SHALL pass KEY and SW each through a two-flop synchronizer before any use.
REQ-021 SHALL hold keyState[3:0], where 1 means pressed (inverted synchronized KEY).
REQ-022 SHALL keep one debounce counter per key; a cycle in which the synchronized value equals keyState clears the counter.
REQ-023 SHALL increment a key's counter on each cycle in which the synchronized value differs from keyState.
REQ-024 SHALL load the new value into keyState and clear the counter on the edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ.
REQ-025 SHALL make a clean KEY change visible in keyState on the DEBOUNCE_CYCLES+2nd rising edge after the change.
REQ-026 SHALL set keyEdge[i] on the edge where keyState[i] goes 0 to 1; a release SHALL NOT set it.
REQ-027 SHALL clear each keyEdge bit written with 1 by a store to ADDR_KEYEDGE (write-1-to-clear); if set and clear hit the same bit on the same edge, set SHALL win.
REQ-028 SHALL write dataIn[23:0] to hexOut on the rising edge where wrEn=1 and addr==ADDR_HEX.
REQ-029 SHALL write dataIn[9:0] to LEDR on the rising edge where wrEn=1 and addr==ADDR_LEDR.
REQ-030 SHALL ignore stores to ADDR_LEDG, ADDR_KEY, ADDR_SW and unmatched addresses.
REQ-031 SHALL drive dataOut combinationally from addr with zero-cycle latency: HEX->{8'b0,hexOut}, LEDR->{22'b0,LEDR}, KEY->{28'b0,keyState}, SW->{22'b0,synchronized SW}, KEYEDGE->{28'b0,keyEdge}, LEDG or unmatched->0.
REQ-032 SHALL make a store visible to a load of the same address one cycle later, never in the same cycle.
REQ-033 SHALL drive ioHit combinationally, independent of wrEn.

Reset
REQ-034 SHALL, on a rising edge with reset=1, clear hexOut, LEDR, keyState, keyEdge, all debounce counters and synchronizer flops to 0.
REQ-035 SHALL give reset priority over any simultaneous store; a debounce in progress SHALL be abandoned.

Configuration
REQ-036 SHALL, with macro IO_KEY_DEBOUNCE_EN defined, implement REQ-022 to REQ-025.
REQ-037 SHALL, without IO_KEY_DEBOUNCE_EN, omit the counters and load keyState from the synchronizer output each cycle (change visible on the 3rd rising edge); DEBOUNCE_CYCLES is then unused.

Verification (DEBOUNCE_CYCLES=4, debounce enabled unless noted)
REQ-038 SHALL check that reset, then a load from 32'hF0000000, 32'hF0000004 and 32'hF0000018, returns 0 each, with LEDR=0 and hexOut=0.
REQ-039 SHALL check that a store of 32'hFFABCDEF to 32'hF0000000 gives hexOut=24'hABCDEF next cycle and a load returning 32'h00ABCDEF.
REQ-040 SHALL check that KEY=4'b1110 held gives keyState=4'b0001 on the 6th edge and keyEdge=4'b0001; KEY bouncing every 2 cycles never changes keyState.
REQ-041 SHALL check that a store of 32'h1 to 32'hF0000018 in the same cycle as a new KEY[0] press edge leaves keyEdge[0]=1, and a later store clears it.
REQ-042 SHALL check that SW=10'h2A5 reads as 32'h000002A5 from 32'hF0000014 after 2 edges, and a load from 32'hF0000020 gives dataOut=0 with ioHit=0.
REQ-043 SHALL check that, without IO_KEY_DEBOUNCE_EN, KEY=4'b0111 gives keyState=4'b1000 on the 3rd edge.

Source files
------------

// File: rtl/io_controller.sv
// Memory-mapped board I/O: HEX/LEDR store registers, synchronized SW/KEY, sticky key-press flags.
// Optional per-key debounce filter enabled by defining IO_KEY_DEBOUNCE_EN.
module io_controller #(
  parameter int              DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX       = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR      = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_LEDG      = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDR_KEY       = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW        = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KEYEDGE   = 32'hF0000018,
  parameter int              DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrEn,
  input  logic [DBITS-1:0] dataIn,
  output logic [DBITS-1:0] dataOut,
  output logic             ioHit,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [23:0]      hexOut
);

  logic hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, hit_keyedge;

  logic [3:0]  key_meta, key_sync;
  logic [9:0]  sw_meta, sw_sync;
  logic [3:0]  key_raw;
  logic [3:0]  key_state, key_state_nxt;
  logic [3:0]  key_edge, key_rise, key_clr;
  logic [23:0] hex_reg;
  logic [9:0]  ledr_reg;

  assign hit_hex     = (addr == ADDR_HEX);
  assign hit_ledr    = (addr == ADDR_LEDR);
  assign hit_ledg    = (addr == ADDR_LEDG);
  assign hit_key     = (addr == ADDR_KEY);
  assign hit_sw      = (addr == ADDR_SW);
  assign hit_keyedge = (addr == ADDR_KEYEDGE);

  assign ioHit = hit_hex | hit_ledr | hit_ledg | hit_key | hit_sw | hit_keyedge;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta <= '0;
      key_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= KEY;
      key_sync <= key_meta;
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
    end
  end

  // Buttons are active-low on the board; internally 1 means pressed.
  assign key_raw = ~key_sync;

`ifdef IO_KEY_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_raw[i] == key_state[i] || db_cnt[i] == CNT_LAST)
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    key_state_nxt = key_state;
    for (int i = 0; i < 4; i++) begin
      if (key_raw[i] != key_state[i] && db_cnt[i] == CNT_LAST)
        key_state_nxt[i] = key_raw[i];
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign key_state_nxt = key_raw;
`endif

  // Set takes precedence over a same-edge write-1-to-clear.
  assign key_rise = key_state_nxt & ~key_state;
  assign key_clr  = (wrEn && hit_keyedge) ? dataIn[3:0] : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_state <= '0;
      key_edge  <= '0;
      hex_reg   <= '0;
      ledr_reg  <= '0;
    end else begin
      key_state <= key_state_nxt;
      key_edge  <= (key_edge & ~key_clr) | key_rise;
      if (wrEn && hit_hex)  hex_reg  <= dataIn[23:0];
      if (wrEn && hit_ledr) ledr_reg <= dataIn[9:0];
    end
  end

  assign hexOut = hex_reg;
  assign LEDR   = ledr_reg;

  always_comb begin
    dataOut = '0;
    if (hit_hex)          dataOut[23:0] = hex_reg;
    else if (hit_ledr)    dataOut[9:0]  = ledr_reg;
    else if (hit_key)     dataOut[3:0]  = key_state;
    else if (hit_sw)      dataOut[9:0]  = sw_sync;
    else if (hit_keyedge) dataOut[3:0]  = key_edge;
  end

  logic unused_data_bits;
  assign unused_data_bits = ^dataIn[DBITS-1:24];

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: store/load register table plus key, switch and reset sequences.
module tb_io_controller;

  localparam int DB = 4;
  localparam logic [31:0] A_HEX  = 32'hF0000000;
  localparam logic [31:0] A_LEDR = 32'hF0000004;
  localparam logic [31:0] A_LEDG = 32'hF0000008;
  localparam logic [31:0] A_KEY  = 32'hF0000010;
  localparam logic [31:0] A_SW   = 32'hF0000014;
  localparam logic [31:0] A_KE   = 32'hF0000018;
  localparam logic [31:0] A_NONE = 32'hF0000020;

`ifdef IO_KEY_DEBOUNCE_EN
  localparam int         LAT   = DB + 2;
  localparam logic [3:0] PRESS = 4'b1110;
  localparam logic [3:0] MASK  = 4'b0001;
`else
  localparam int         LAT   = 3;
  localparam logic [3:0] PRESS = 4'b0111;
  localparam logic [3:0] MASK  = 4'b1000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wrEn;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        ioHit;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [23:0] hexOut;

  int n_checks = 0;
  int n_fail   = 0;

  io_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrEn(wrEn), .dataIn(dataIn),
    .dataOut(dataOut), .ioHit(ioHit), .KEY(KEY), .SW(SW), .LEDR(LEDR), .hexOut(hexOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        hit;
    logic [9:0]  ledr;
    logic [23:0] hex;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dataOut, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; dataIn = d; wrEn = 1'b1;
    tick();
    wrEn = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0,   32'h0,        A_HEX,  32'h0,        1'b1, 10'h000, 24'h000000};
    vecs[1]  = '{1'b0, 32'h0,   32'h0,        A_LEDR, 32'h0,        1'b1, 10'h000, 24'h000000};
    vecs[2]  = '{1'b0, 32'h0,   32'h0,        A_KE,   32'h0,        1'b1, 10'h000, 24'h000000};
    vecs[3]  = '{1'b1, A_HEX,   32'hFFABCDEF, A_HEX,  32'h00ABCDEF, 1'b1, 10'h000, 24'hABCDEF};
    vecs[4]  = '{1'b1, A_LEDR,  32'hFFFFF6A5, A_LEDR, 32'h000002A5, 1'b1, 10'h2A5, 24'hABCDEF};
    vecs[5]  = '{1'b1, A_LEDG,  32'hFFFFFFFF, A_LEDG, 32'h0,        1'b1, 10'h2A5, 24'hABCDEF};
    vecs[6]  = '{1'b1, A_KEY,   32'hFFFFFFFF, A_KEY,  32'h0,        1'b1, 10'h2A5, 24'hABCDEF};
    vecs[7]  = '{1'b1, A_SW,    32'hFFFFFFFF, A_SW,   32'h0,        1'b1, 10'h2A5, 24'hABCDEF};
    vecs[8]  = '{1'b1, A_NONE,  32'hFFFFFFFF, A_NONE, 32'h0,        1'b0, 10'h2A5, 24'hABCDEF};
    vecs[9]  = '{1'b1, 32'hF000000C, 32'h0,   A_HEX,  32'h00ABCDEF, 1'b1, 10'h2A5, 24'hABCDEF};
    vecs[10] = '{1'b1, A_HEX,   32'h00123456, A_LEDR, 32'h000002A5, 1'b1, 10'h2A5, 24'h123456};
    vecs[11] = '{1'b1, A_LEDR,  32'h0,        A_HEX,  32'h00123456, 1'b1, 10'h000, 24'h123456};

    reset = 1'b1; wrEn = 1'b0; addr = '0; dataIn = '0; KEY = 4'hF; SW = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_hexOut", 32'(hexOut), 32'h0);
    check("rst_LEDR", 32'(LEDR), 32'h0);
    rd(A_HEX, "rst_ld_hex", 32'h0);
    rd(A_LEDR, "rst_ld_ledr", 32'h0);
    rd(A_KE, "rst_ld_keyedge", 32'h0);
    rd(A_KEY, "rst_ld_key", 32'h0);

    // Let the released-key level settle through the synchronizers, then drop any start-up flags.
    repeat (4) tick();
    store(A_KE, 32'hF);

    for (int i = 0; i < 12; i++) begin
      addr = vecs[i].waddr; dataIn = vecs[i].wdata; wrEn = vecs[i].wr;
      tick();
      wrEn = 1'b0;
      addr = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d_dout", i), dataOut, vecs[i].rdata);
      check($sformatf("vec%0d_hit", i), 32'(ioHit), 32'(vecs[i].hit));
      check($sformatf("vec%0d_ledr", i), 32'(LEDR), 32'(vecs[i].ledr));
      check($sformatf("vec%0d_hex", i), 32'(hexOut), 32'(vecs[i].hex));
    end

    // Store is not visible in the cycle it is issued.
    addr = A_HEX; dataIn = 32'h00777777; wrEn = 1'b1;
    #1;
    check("same_cycle_old", dataOut, 32'h00123456);
    tick();
    wrEn = 1'b0;
    check("next_cycle_new", dataOut, 32'h00777777);

    SW = 10'h2A5; addr = A_SW;
    tick();
    check("sw_one_edge", dataOut, 32'h0);
    tick();
    check("sw_two_edges", dataOut, 32'h000002A5);
    rd(A_NONE, "unmapped_dout", 32'h0);
    check("unmapped_hit", 32'(ioHit), 32'h0);

    KEY = PRESS; addr = A_KEY;
    repeat (LAT - 1) tick();
    check("key_before_lat", dataOut, 32'h0);
    tick();
    check("key_at_lat", dataOut, 32'(MASK));
    rd(A_KE, "keyedge_set", 32'(MASK));
    store(A_KE, 32'(MASK));
    rd(A_KE, "keyedge_clr", 32'h0);

    KEY = 4'hF;
    repeat (LAT) tick();
    rd(A_KEY, "key_release", 32'h0);
    rd(A_KE, "release_no_edge", 32'h0);

`ifdef IO_KEY_DEBOUNCE_EN
    addr = A_KEY;
    for (int c = 0; c < 24; c++) begin
      KEY = ((c / 2) % 2 == 1) ? 4'hF : PRESS;
      tick();
      check($sformatf("bounce%0d", c), dataOut, 32'h0);
    end
    KEY = 4'hF;
    repeat (LAT) tick();
    rd(A_KE, "bounce_no_edge", 32'h0);
`endif

    KEY = PRESS;
    repeat (LAT - 1) tick();
    store(A_KE, 32'hF);
    rd(A_KE, "set_beats_clr", 32'(MASK));
    rd(A_KEY, "key_repressed", 32'(MASK));
    store(A_KE, 32'(MASK));
    rd(A_KE, "later_clr", 32'h0);

    store(A_LEDR, 32'h155);
    check("ledr_before_rst", 32'(LEDR), 32'h155);
    reset = 1'b1; addr = A_HEX; dataIn = 32'hDEADBEEF; wrEn = 1'b1;
    tick();
    reset = 1'b0; wrEn = 1'b0;
    check("rst_wins_hex", 32'(hexOut), 32'h0);
    check("rst_wins_ledr", 32'(LEDR), 32'h0);
    rd(A_KEY, "rst_keystate", 32'h0);
    rd(A_KE, "rst_keyedge", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
